// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multicycle control unit and its datapath/memory.
// The master side is the control unit; the slave side is the datapath that obeys it.
interface multicycle_control_unit_if #(
   parameter int unsigned OPCODE_W = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                resume;

   logic                RegWrite;
   logic                MemWrite;
   logic                MemRead;
   logic                ALUSrc;
   logic                RegWriteSrc;
   logic                IRWrite;
   logic                PCWrite;
   logic [1:0]          PCSrc;

   logic                halted;
   logic                mem_fault;
   logic                illegal_op;
   logic                instr_done;
   logic [2:0]          state;

   modport master (
      input  opcode, zero, mem_ready, resume,
      output RegWrite, MemWrite, MemRead, ALUSrc, RegWriteSrc, IRWrite, PCWrite, PCSrc,
      output halted, mem_fault, illegal_op, instr_done, state
   );

   modport slave (
      output opcode, zero, mem_ready, resume,
      input  RegWrite, MemWrite, MemRead, ALUSrc, RegWriteSrc, IRWrite, PCWrite, PCSrc,
      input  halted, mem_fault, illegal_op, instr_done, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory wait-timeout
// that parks the machine in HALT with a sticky fault until resumed.
module multicycle_control_unit #(
   parameter int unsigned OPCODE_W = 3,
   parameter int unsigned TIMEOUT  = 15
) (
   input logic                       clk,
   input logic                       rst,
   multicycle_control_unit_if.master bus
);

   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StHalt   = 3'd5;

   localparam logic [2:0] OpAlu    = 3'd0;
   localparam logic [2:0] OpLoad   = 3'd1;
   localparam logic [2:0] OpStore  = 3'd2;
   localparam logic [2:0] OpAluImm = 3'd3;
   localparam logic [2:0] OpBeqz   = 3'd4;
   localparam logic [2:0] OpJump   = 3'd5;
   localparam logic [2:0] OpNop    = 3'd6;
   localparam logic [2:0] OpHalt   = 3'd7;

   // The wait that would be the TIMEOUT-th consecutive one is the last one tolerated.
   localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

   logic [2:0]          state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [7:0]          wait_cnt_q, wait_cnt_d;
   logic                mem_fault_q, mem_fault_d;

   logic [31:0] op_ext;
   logic        op_illegal;
   logic [2:0]  op_kind;
   logic        wait_expired;
   logic        in_wait_state;

   logic       reg_write, mem_write, mem_read, alu_src, reg_write_src, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       halted, illegal_op, instr_done;

   // Opcodes beyond the eight defined ones behave as NOP but are flagged.
   always_comb begin
      op_ext     = 32'(op_q);
      op_illegal = op_ext > 32'd7;
      op_kind    = op_illegal ? OpNop : op_ext[2:0];
   end

   always_comb begin
      in_wait_state = (state_q == StFetch) || (state_q == StMem);
      wait_expired  = (wait_cnt_q == WaitLast) && !bus.mem_ready;
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      mem_fault_d   = mem_fault_q;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      alu_src       = 1'b0;
      reg_write_src = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      halted        = 1'b0;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;

      case (state_q)
         StFetch: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (wait_expired) begin
               mem_fault_d = 1'b1;
               state_d     = StHalt;
            end
         end

         StDecode: begin
            op_d    = bus.opcode;
            state_d = StExec;
         end

         StExec: begin
            illegal_op = op_illegal;
            case (op_kind)
               OpAlu: begin
                  state_d = StWb;
               end
               OpAluImm: begin
                  alu_src = 1'b1;
                  state_d = StWb;
               end
               OpLoad, OpStore: begin
                  alu_src = 1'b1;
                  state_d = StMem;
               end
               OpBeqz: begin
                  pc_src     = 2'b01;
                  pc_write   = bus.zero;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               OpJump: begin
                  pc_src     = 2'b10;
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               OpHalt: begin
                  instr_done = 1'b1;
                  state_d    = StHalt;
               end
               default: begin
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end

         StMem: begin
            if (op_kind == OpLoad) begin
               mem_read = 1'b1;
               alu_src  = 1'b1;
               if (bus.mem_ready) begin
                  state_d = StWb;
               end else if (wait_expired) begin
                  mem_fault_d = 1'b1;
                  state_d     = StHalt;
               end
            end else if (op_kind == OpStore) begin
               mem_write = 1'b1;
               alu_src   = 1'b1;
               if (bus.mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end else if (wait_expired) begin
                  mem_fault_d = 1'b1;
                  state_d     = StHalt;
               end
            end else begin
               state_d = StFetch;
            end
         end

         StWb: begin
            reg_write     = 1'b1;
            reg_write_src = (op_kind == OpLoad);
            alu_src       = (op_kind == OpLoad) || (op_kind == OpAluImm);
            instr_done    = 1'b1;
            state_d       = StFetch;
         end

         StHalt: begin
            halted = 1'b1;
            if (bus.resume) begin
               mem_fault_d = 1'b0;
               state_d     = StFetch;
            end
         end

         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // Counts consecutive unanswered cycles; any state change or handshake restarts it.
   always_comb begin
      if ((state_d != state_q) || bus.mem_ready || !in_wait_state) begin
         wait_cnt_d = 8'd0;
      end else begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFetch;
         op_q        <= '0;
         wait_cnt_q  <= 8'd0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   // Strobes are held low while reset is asserted so an aborted access cannot write.
   assign bus.RegWrite    = reg_write & ~rst;
   assign bus.MemWrite    = mem_write & ~rst;
   assign bus.MemRead     = mem_read & ~rst;
   assign bus.ALUSrc      = alu_src & ~rst;
   assign bus.RegWriteSrc = reg_write_src & ~rst;
   assign bus.IRWrite     = ir_write & ~rst;
   assign bus.PCWrite     = pc_write & ~rst;
   assign bus.PCSrc       = rst ? 2'b00 : pc_src;
   assign bus.halted      = halted & ~rst;
   assign bus.illegal_op  = illegal_op & ~rst;
   assign bus.instr_done  = instr_done & ~rst;
   assign bus.mem_fault   = mem_fault_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised scoreboard bench: per-instruction expected activity totals are queued by the
// driver and compared by an independent monitor at each instruction or halt boundary.
module tb_multicycle_control_unit;

   localparam int T = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OPCODE_W(4)) bus ();

   multicycle_control_unit #(
      .OPCODE_W (4),
      .TIMEOUT  (T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   typedef struct {
      bit is_halt;
      int cycles;
      int rd;
      int wr;
      int rw;
      int src;
      int alus;
      int pcw;
      int pcs;
      int irw;
      int ill;
      int done;
      bit fault;
   } exp_t;

   exp_t sb[$];
   bit   mon_en = 1'b0;

   // Expected totals from the instruction semantics: cycles per phase and strobes per phase.
   task automatic predict(input int op, input int z, input int fw, input int mw, input int hold,
                          output exp_t e, output exp_t h, output bit halts);
      int kind;
      e     = '{default: 0};
      h     = '{default: 0};
      halts = 1'b0;
      kind  = (op >= 8) ? 6 : op;
      h.is_halt = 1'b1;
      h.cycles  = hold + 1;
      if (fw >= T) begin
         e.cycles = T;
         e.rd     = T;
         e.fault  = 1'b1;
         halts    = 1'b1;
      end else begin
         e.cycles = fw + 1 + 2;
         e.rd     = fw + 1;
         e.irw    = 1;
         e.pcw    = 1;
         e.done   = 1;
         e.ill    = (op >= 8) ? 1 : 0;
         case (kind)
            0: begin e.cycles += 1; e.rw = 1; end
            3: begin e.cycles += 1; e.rw = 1; e.alus = 2; end
            1: begin
               if (mw >= T) begin
                  e.cycles += T; e.rd += T; e.alus = 1 + T;
                  e.fault = 1'b1; e.done = 0; halts = 1'b1;
               end else begin
                  e.cycles += mw + 2; e.rd += mw + 1; e.alus = mw + 3;
                  e.rw = 1; e.src = 1;
               end
            end
            2: begin
               if (mw >= T) begin
                  e.cycles += T; e.wr = T; e.alus = 1 + T;
                  e.fault = 1'b1; e.done = 0; halts = 1'b1;
               end else begin
                  e.cycles += mw + 1; e.wr = mw + 1; e.alus = mw + 2;
               end
            end
            4: begin e.pcs = 1; e.pcw += z; end
            5: begin e.pcs = 2; e.pcw += 1; end
            7: halts = 1'b1;
            default: ;
         endcase
      end
      h.fault = e.fault;
   endtask

   // Monitor state
   int m_cyc, m_rd, m_wr, m_rw, m_src, m_alus, m_pcw, m_pcs, m_irw, m_ill, m_done;
   int h_cnt, h_ctl, h_state_bad, h_mf_changes;
   bit h_mf_first;

   function automatic int ctl_any();
      return int'(bus.RegWrite | bus.MemWrite | bus.MemRead | bus.ALUSrc | bus.RegWriteSrc |
                  bus.IRWrite | bus.PCWrite | (|bus.PCSrc) | bus.illegal_op | bus.instr_done);
   endfunction

   function automatic void clear_instr();
      m_cyc = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_src = 0; m_alus = 0;
      m_pcw = 0; m_pcs = 0; m_irw = 0; m_ill = 0; m_done = 0;
   endfunction

   function automatic void clear_halt();
      h_cnt = 0; h_ctl = 0; h_state_bad = 0; h_mf_changes = 0; h_mf_first = 1'b0;
   endfunction

   function automatic void close_instr();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow_instr", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("rec_kind_instr", int'(e.is_halt), 0);
         chk("instr_cycles", m_cyc, e.cycles);
         chk("instr_memread", m_rd, e.rd);
         chk("instr_memwrite", m_wr, e.wr);
         chk("instr_regwrite", m_rw, e.rw);
         chk("instr_regwsrc", m_src, e.src);
         chk("instr_alusrc", m_alus, e.alus);
         chk("instr_pcwrite", m_pcw, e.pcw);
         chk("instr_pcsrc", m_pcs, e.pcs);
         chk("instr_irwrite", m_irw, e.irw);
         chk("instr_illegal", m_ill, e.ill);
         chk("instr_done", m_done, e.done);
      end
      clear_instr();
   endfunction

   function automatic void close_halt();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow_halt", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("rec_kind_halt", int'(e.is_halt), 1);
         chk("halt_cycles", h_cnt, e.cycles);
         chk("halt_mem_fault", int'(h_mf_first), int'(e.fault));
         chk("halt_fault_stable", h_mf_changes, 0);
         chk("halt_ctl_quiet", h_ctl, 0);
         chk("halt_state_code", h_state_bad, 0);
         chk("resume_clears_fault", int'(bus.mem_fault), 0);
      end
      clear_halt();
   endfunction

   always @(negedge clk) begin
      if (!mon_en) begin
         clear_instr();
         clear_halt();
      end else if (!bus.halted) begin
         if (h_cnt > 0) close_halt();
         m_cyc++;
         m_rd   += int'(bus.MemRead);
         m_wr   += int'(bus.MemWrite);
         m_rw   += int'(bus.RegWrite);
         m_src  += int'(bus.RegWriteSrc);
         m_alus += int'(bus.ALUSrc);
         m_pcw  += int'(bus.PCWrite);
         m_pcs  |= int'(bus.PCSrc);
         m_irw  += int'(bus.IRWrite);
         m_ill  += int'(bus.illegal_op);
         m_done += int'(bus.instr_done);
         if (bus.instr_done) close_instr();
      end else begin
         if (m_cyc > 0) close_instr();
         if (h_cnt == 0) h_mf_first = bus.mem_fault;
         else if (bus.mem_fault != h_mf_first) h_mf_changes++;
         h_cnt++;
         h_ctl       += ctl_any();
         h_state_bad += (bus.state != 3'd5) ? 1 : 0;
      end
   end

   // Driver
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.resume    = ($urandom_range(0, 3) == 0);
      bus.zero      = 1'($urandom_range(0, 1));
      bus.opcode    = 4'($urandom_range(0, 15));
   endtask

   task automatic halt_phase(input int hold);
      for (int i = 0; i < hold; i++) begin
         noise();
         bus.resume = 1'b0;
         step();
      end
      noise();
      bus.resume = 1'b1;
      step();
      bus.resume = 1'b0;
   endtask

   task automatic run_instr(input int op, input int z, input int fw, input int mw, input int hold);
      exp_t e, h;
      bit   halts;
      int   kind, n;
      predict(op, z, fw, mw, hold, e, h, halts);
      sb.push_back(e);
      if (halts) sb.push_back(h);
      kind = (op >= 8) ? 6 : op;
      n = (fw >= T) ? T : fw + 1;
      for (int i = 0; i < n; i++) begin
         noise();
         bus.mem_ready = (fw < T) && (i == fw);
         step();
      end
      if (fw >= T) begin
         halt_phase(hold);
         return;
      end
      noise();
      bus.opcode = 4'(op);
      step();
      noise();
      bus.zero = 1'(z);
      step();
      if (kind == 1 || kind == 2) begin
         n = (mw >= T) ? T : mw + 1;
         for (int i = 0; i < n; i++) begin
            noise();
            bus.mem_ready = (mw < T) && (i == mw);
            step();
         end
         if (mw >= T) begin
            halt_phase(hold);
            return;
         end
      end
      if (kind == 0 || kind == 1 || kind == 3) begin
         noise();
         step();
      end
      if (kind == 7) halt_phase(hold);
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12) return int'($urandom_range(0, 3));
      if (r < 15) return T - 1;
      if (r < 16) return T;
      return int'($urandom_range(4, T - 2));
   endfunction

   task automatic do_reset();
      rst           = 1'b1;
      bus.mem_ready = 1'b1;
      bus.resume    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_halted", int'(bus.halted), 0);
      chk("rst_instr_done", int'(bus.instr_done), 0);
      chk("rst_illegal", int'(bus.illegal_op), 0);
      chk("rst_memread", int'(bus.MemRead), 0);
      chk("rst_state", int'(bus.state), 0);
      chk("rst_mem_fault", int'(bus.mem_fault), 0);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.mem_ready = 1'b0;
      bus.resume    = 1'b0;
   endtask

   int load_states[6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      int done_cnt;
      bus.opcode    = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      bus.resume    = 1'b0;

      do_reset();

      // LOAD with memory always ready walks every state once.
      bus.mem_ready = 1'b1;
      bus.opcode    = 4'd1;
      done_cnt      = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("load_state_%0d", i), int'(bus.state), load_states[i]);
         chk($sformatf("load_regwrite_%0d", i), int'(bus.RegWrite), (i == 4) ? 1 : 0);
         chk($sformatf("load_regwsrc_%0d", i), int'(bus.RegWriteSrc), (i == 4) ? 1 : 0);
         if (i == 0) chk("fetch_memread_after_rst", int'(bus.MemRead), 1);
         done_cnt += int'(bus.instr_done);
         step();
      end
      chk("load_done_count", done_cnt, 1);

      do_reset();
      mon_en = 1'b1;

      run_instr(2, 0, 0, T, 2);
      run_instr(1, 0, 1, T - 1, 0);
      run_instr(2, 0, T - 1, 0, 0);
      run_instr(9, 0, 0, 0, 0);
      run_instr(4, 0, 0, 0, 0);
      run_instr(4, 1, 0, 0, 0);
      run_instr(5, 0, 2, 0, 0);
      run_instr(7, 0, 0, 0, 3);
      run_instr(3, 0, T, 0, 1);
      for (int n = 0; n < 160; n++) begin
         run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), pick_wait(),
                   pick_wait(), int'($urandom_range(0, 3)));
      end
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("scoreboard_drained", sb.size(), 0);

      // Reset in the middle of a stalled STORE aborts it and restarts the wait count.
      do_reset();
      bus.mem_ready = 1'b1;
      bus.opcode    = 4'd2;
      step();
      bus.mem_ready = 1'b0;
      step();
      bus.opcode = 4'd0;
      step();
      repeat (5) step();
      @(negedge clk);
      chk("mid_store_state", int'(bus.state), 3);
      chk("mid_store_memwrite", int'(bus.MemWrite), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_memwrite_in_rst", int'(bus.MemWrite), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_state", int'(bus.state), 0);
      chk("abort_memwrite", int'(bus.MemWrite), 0);
      chk("abort_memread", int'(bus.MemRead), 1);
      @(posedge clk);
      #1;
      repeat (T - 2) step();
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("abort_cnt_cleared_halted", int'(bus.halted), 0);
      chk("abort_cnt_cleared_irwrite", int'(bus.IRWrite), 1);
      step();
      @(negedge clk);
      chk("abort_then_decode", int'(bus.state), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL provide parameter OPCODE_W, 3, opcode width; legal values >= 3.
REQ-002 SHALL provide parameter TIMEOUT, 15, maximum wait cycles for mem_ready before fault; legal values 1..255.
REQ-003 SHALL provide port clk input 1, single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst input 1, synchronous active-high reset.
REQ-005 SHALL provide port opcode input OPCODE_W, instruction opcode from IR, sampled in DECODE.
REQ-006 SHALL provide port zero input 1, ALU zero flag, sampled in EXEC.
REQ-007 SHALL provide port mem_ready input 1, memory access-complete strobe.
REQ-008 SHALL provide port resume input 1, leave HALT.
REQ-009 SHALL provide ports RegWrite, MemWrite, MemRead, ALUSrc, RegWriteSrc, IRWrite, PCWrite output 1 each, datapath controls.
REQ-010 SHALL provide port PCSrc output 2, PC source: 00 PC+1, 01 branch target, 10 jump target.
REQ-011 SHALL provide ports halted, mem_fault, illegal_op, instr_done output 1 each, status.
REQ-012 SHALL provide port state output 3, current FSM state encoding.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 unreachable, recover to FETCH next cycle.
REQ-014 SHALL latch opcode into an internal register on the DECODE cycle; later states use only the latched value.
REQ-015 SHALL decode latched opcode: 0 ALU reg-reg, 1 LOAD, 2 STORE, 3 ALU-imm, 4 BEQZ, 5 JUMP, 6 NOP, 7 HALT; values >= 8 decode as NOP and pulse illegal_op for 1 cycle in EXEC.
REQ-016 SHALL drive all control outputs as Moore/Mealy combinational functions of state, latched opcode, zero, mem_ready; unlisted outputs 0.
REQ-017 FETCH: MemRead=1; on mem_ready IRWrite=1, PCWrite=1, PCSrc=00, next DECODE; else stay.
REQ-018 DECODE: all controls 0, next EXEC unconditionally (1 cycle).
REQ-019 EXEC: ALUSrc=1 for LOAD, STORE, ALU-imm; ALU ops/LOAD/STORE -> WB/MEM/MEM respectively (ALU -> WB).
REQ-020 EXEC BEQZ: PCSrc=01, PCWrite=zero, instr_done=1, next FETCH.
REQ-021 EXEC JUMP: PCSrc=10, PCWrite=1, instr_done=1, next FETCH; NOP/illegal: instr_done=1, next FETCH; HALT: instr_done=1, next HALT.
REQ-022 MEM LOAD: MemRead=1, ALUSrc=1; on mem_ready next WB. MEM STORE: MemWrite=1, ALUSrc=1; on mem_ready instr_done=1, next FETCH.
REQ-023 WB: RegWrite=1, RegWriteSrc=1 for LOAD else 0, ALUSrc=1 for LOAD/ALU-imm, instr_done=1, next FETCH.
REQ-024 SHALL count consecutive wait cycles (mem_ready=0) in FETCH and MEM; counter clears on state entry and on mem_ready.
REQ-025 When wait count reaches TIMEOUT with mem_ready still 0, SHALL set mem_fault=1 (sticky) and enter HALT next cycle, deasserting MemRead/MemWrite.
REQ-026 mem_ready in the same cycle the count reaches TIMEOUT SHALL win: normal transition, no fault.
REQ-027 HALT: halted=1, all controls 0; resume=1 -> FETCH next cycle, clears mem_fault; resume outside HALT ignored.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 Minimum latency: ALU 4 cycles, LOAD 5, STORE 4, BEQZ/JUMP/NOP 3 (mem_ready=1 throughout).

Reset
REQ-030 rst=1 SHALL force state FETCH, wait counter 0, latched opcode 0, mem_fault 0 on the next edge; overrides resume and mem_ready.
REQ-031 During and after reset, status outputs SHALL read halted=0, illegal_op=0, instr_done=0; FETCH outputs (MemRead=1) appear the cycle after rst falls.
REQ-032 rst mid-access (MEM, wait) SHALL abort the access; no further MemWrite/RegWrite for that instruction.

Verification
REQ-033 mem_ready=1 constant, opcode=1 (LOAD) -> states 0,1,2,3,4,0; RegWrite=1 and RegWriteSrc=1 only in cycle 5; instr_done once.
REQ-034 opcode=4, zero=0 then zero=1 -> PCWrite=0 then 1 in EXEC, PCSrc=01 both times.
REQ-035 TIMEOUT=15, STORE, mem_ready held 0 in MEM -> MemWrite high 15 cycles, mem_fault=1, state=5; resume pulse -> state 0, mem_fault=0.
REQ-036 mem_ready asserted on exactly the 15th wait cycle -> no fault, normal transition.
REQ-037 OPCODE_W=4, opcode=9 -> illegal_op pulse in EXEC, returns to FETCH, no write strobes.
REQ-038 rst asserted in MEM wait of STORE -> state 0 next cycle, MemWrite=0, counter 0.
